// File: rtl/divider_pkg.sv
// Shared widths and the tag that travels alongside each divide through the pipeline.
package divider_pkg;

  localparam int DIVIDEND       = 16;
  localparam int DIVISOR        = 8;
  localparam int MAX_REQUESTERS = 16;
  localparam int TAG_INDEX_W    = $clog2(MAX_REQUESTERS);

  typedef struct packed {
    logic                   valid;
    logic [TAG_INDEX_W-1:0] index;
    logic                   dbz;
  } div_tag_t;

endpackage

// File: rtl/divider_scheduler_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a
// registered pointer that moves just past each accepted requester.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  request,
  input  logic          enable,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_index
);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] pos_s;
  logic          found_s;
  int            pos_int_s;

  // First active request at or after ptr (with wrap) wins
  always_comb begin
    grant       = '0;
    grant_index = '0;
    found_s     = 1'b0;
    pos_int_s   = 0;
    pos_s       = '0;
    for (int k = 0; k < N; k++) begin
      pos_int_s = int'(ptr_r) + k;
      if (pos_int_s >= N) begin
        pos_int_s = pos_int_s - N;
      end else begin
        pos_int_s = pos_int_s;
      end
      pos_s = IW'(pos_int_s);
      if (enable && !found_s && request[pos_s]) begin
        found_s     = 1'b1;
        grant_index = pos_s;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      grant[grant_index] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Pointer register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (grant_index == IW'(N - 1)) ? '0 : grant_index + IW'(1);
    end
  end

endmodule

// File: rtl/divider_scheduler.sv
// Shares one fixed-latency pipelined divider among several requesters, tagging
// each operation so its result returns to the issuer LATENCY+1 edges later.
module divider_scheduler #(
  parameter  int DIVIDEND   = divider_pkg::DIVIDEND,
  parameter  int DIVISOR    = divider_pkg::DIVISOR,
  parameter  int REQUESTERS = 4,
  parameter  int LATENCY    = 16,
  localparam int IFW        = $clog2(LATENCY + 3)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           hold,
  input  logic [REQUESTERS-1:0]          req_valid,
  output logic [REQUESTERS-1:0]          req_ready,
  input  logic [REQUESTERS*DIVIDEND-1:0] req_dividend,
  input  logic [REQUESTERS*DIVISOR-1:0]  req_divisor,
  output logic [DIVIDEND-1:0]            div_dividend,
  output logic [DIVISOR-1:0]             div_divisor,
  input  logic [DIVIDEND-1:0]            div_quotient,
  input  logic [DIVISOR-1:0]             div_remainder,
  output logic [REQUESTERS-1:0]          rsp_valid,
  output logic [DIVIDEND-1:0]            rsp_quotient,
  output logic [DIVISOR-1:0]             rsp_remainder,
  output logic                           rsp_dbz,
  output logic [IFW-1:0]                 inflight,
  output logic                           busy
);

  import divider_pkg::*;

  localparam int IW = $clog2(REQUESTERS);

  logic [REQUESTERS-1:0] grant_s;
  logic [IW-1:0]         grant_index_s;
  logic                  accept_s;
  logic [DIVIDEND-1:0]   sel_dividend_s;
  logic [DIVISOR-1:0]    sel_divisor_s;
  div_tag_t              new_tag_s;
  div_tag_t              rsp_tag_s;
  div_tag_t              tag_r [0:LATENCY];
  logic [REQUESTERS-1:0] rsp_onehot_s;
  logic [IFW-1:0]        inflight_next_s;

  logic [DIVIDEND-1:0]   div_dividend_r;
  logic [DIVISOR-1:0]    div_divisor_r;
  logic [REQUESTERS-1:0] rsp_valid_r;
  logic [DIVIDEND-1:0]   rsp_quotient_r;
  logic [DIVISOR-1:0]    rsp_remainder_r;
  logic                  rsp_dbz_r;
  logic [IFW-1:0]        inflight_r;
  logic                  busy_r;

  rr_arbiter #(.N(REQUESTERS)) u_arbiter (
    .clock       (clock),
    .reset       (reset),
    .request     (req_valid),
    .enable      (!hold),
    .advance     (accept_s),
    .grant       (grant_s),
    .grant_index (grant_index_s)
  );

  // A grant only exists for a valid request, so any grant is an accept
  assign accept_s  = |grant_s;
  assign req_ready = grant_s;
  assign rsp_tag_s = tag_r[LATENCY];

  // Select the granted requester's operands and build its tag
  always_comb begin
    sel_dividend_s  = req_dividend[grant_index_s*DIVIDEND +: DIVIDEND];
    sel_divisor_s   = req_divisor[grant_index_s*DIVISOR +: DIVISOR];
    new_tag_s.valid = accept_s;
    new_tag_s.index = TAG_INDEX_W'(grant_index_s);
    new_tag_s.dbz   = accept_s && (sel_divisor_s == '0);
  end

  // Operand registers feeding the divider; they hold between accepts
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_dividend_r <= '0;
      div_divisor_r  <= '0;
    end else if (accept_s) begin
      div_dividend_r <= sel_dividend_s;
      div_divisor_r  <= sel_divisor_s;
    end
  end

  // Tag pipeline, one stage deeper than the divider so it lines up with the capture edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_r[s] <= '0;
      end
    end else begin
      tag_r[0] <= new_tag_s;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

  // One-hot response strobe at the returning tag's index
  always_comb begin
    rsp_onehot_s = '0;
    if (rsp_tag_s.valid) begin
      rsp_onehot_s[rsp_tag_s.index[IW-1:0]] = 1'b1;
    end else begin
      rsp_onehot_s = '0;
    end
  end

  // Response registers; divide-by-zero overrides the divider's output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_r     <= '0;
      rsp_quotient_r  <= '0;
      rsp_remainder_r <= '0;
      rsp_dbz_r       <= 1'b0;
    end else if (rsp_tag_s.valid) begin
      rsp_valid_r <= rsp_onehot_s;
      rsp_dbz_r   <= rsp_tag_s.dbz;
      if (rsp_tag_s.dbz) begin
        rsp_quotient_r  <= '1;
        rsp_remainder_r <= '0;
      end else begin
        rsp_quotient_r  <= div_quotient;
        rsp_remainder_r <= div_remainder;
      end
    end else begin
      rsp_valid_r <= '0;
    end
  end

  // Occupancy: accept adds, response removes, both together cancel
  always_comb begin
    case ({accept_s, rsp_tag_s.valid})
      2'b10:   inflight_next_s = inflight_r + IFW'(1);
      2'b01:   inflight_next_s = inflight_r - IFW'(1);
      default: inflight_next_s = inflight_r;
    endcase
  end

  // Occupancy registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_r <= '0;
      busy_r     <= 1'b0;
    end else begin
      inflight_r <= inflight_next_s;
      busy_r     <= (inflight_next_s != '0);
    end
  end

  assign div_dividend  = div_dividend_r;
  assign div_divisor   = div_divisor_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_quotient  = rsp_quotient_r;
  assign rsp_remainder = rsp_remainder_r;
  assign rsp_dbz       = rsp_dbz_r;
  assign inflight      = inflight_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_divider_scheduler.sv
// Scoreboard bench for divider_scheduler with a behavioural 16-stage divider.
module tb_divider_scheduler;

  localparam int DVD = 16;
  localparam int DVS = 8;
  localparam int REQ = 4;
  localparam int LAT = 16;
  localparam int IFW = $clog2(LAT + 3);

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 hold;
  logic [REQ-1:0]       req_valid;
  logic [REQ-1:0]       req_ready;
  logic [REQ*DVD-1:0]   req_dividend;
  logic [REQ*DVS-1:0]   req_divisor;
  logic [DVD-1:0]       div_dividend;
  logic [DVS-1:0]       div_divisor;
  logic [DVD-1:0]       div_quotient;
  logic [DVS-1:0]       div_remainder;
  logic [REQ-1:0]       rsp_valid;
  logic [DVD-1:0]       rsp_quotient;
  logic [DVS-1:0]       rsp_remainder;
  logic                 rsp_dbz;
  logic [IFW-1:0]       inflight;
  logic                 busy;

  divider_scheduler #(.DIVIDEND(DVD), .DIVISOR(DVS), .REQUESTERS(REQ), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .inflight(inflight), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural divider: result appears LAT edges after the operand registers change
  logic [DVD-1:0] pipe_q [LAT];
  logic [DVS-1:0] pipe_r [LAT];
  always @(posedge clock) begin
    if (div_divisor != 8'd0) begin
      pipe_q[0] <= div_dividend / {8'd0, div_divisor};
      pipe_r[0] <= DVS'(div_dividend % {8'd0, div_divisor});
    end else begin
      pipe_q[0] <= 16'd0;
      pipe_r[0] <= 8'd0;
    end
    for (int s = 1; s < LAT; s++) begin
      pipe_q[s] <= pipe_q[s-1];
      pipe_r[s] <= pipe_r[s-1];
    end
  end
  assign div_quotient  = pipe_q[LAT-1];
  assign div_remainder = pipe_r[LAT-1];

  typedef struct {
    logic [REQ-1:0] onehot;
    logic [DVD-1:0] q;
    logic [DVS-1:0] r;
    logic           dbz;
    int             due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t push_e;
  int checks = 0;
  int errors = 0;

  logic [DVD-1:0] t_q [REQ];
  logic [DVS-1:0] t_r [REQ];
  logic           t_z [REQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per response and flags late or spurious ones
  always @(negedge clock) begin
    if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      check("rsp_missing_cycle", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (rsp_valid != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", {28'd0, rsp_valid}, {28'd0, mon_e.onehot});
        check("rsp_quotient", {16'd0, rsp_quotient}, {16'd0, mon_e.q});
        check("rsp_remainder", {24'd0, rsp_remainder}, {24'd0, mon_e.r});
        check("rsp_dbz", {31'd0, rsp_dbz}, {31'd0, mon_e.dbz});
        check("rsp_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic set_op(input int i, input logic [DVD-1:0] a, input logic [DVS-1:0] b,
                        input logic [DVD-1:0] q, input logic [DVS-1:0] r, input logic z);
    req_dividend[i*DVD +: DVD] = a;
    req_divisor[i*DVS +: DVS]  = b;
    t_q[i] = q;
    t_r[i] = r;
    t_z[i] = z;
  endtask

  // One cycle of stimulus; expected grant is checked and, if any, its result queued
  task automatic drive(input logic [REQ-1:0] v, input logic h, input logic [REQ-1:0] g,
                       input string name);
    @(negedge clock);
    req_valid = v;
    hold      = h;
    #1;
    check(name, {28'd0, req_ready}, {28'd0, g});
    for (int i = 0; i < REQ; i++) begin
      if (g[i]) begin
        push_e.onehot = g;
        push_e.q      = t_q[i];
        push_e.r      = t_r[i];
        push_e.dbz    = t_z[i];
        push_e.due    = cyc + LAT + 2;
        exp_q.push_back(push_e);
      end
    end
  endtask

  task automatic idle();
    @(negedge clock);
    req_valid = 4'b0000;
    hold      = 1'b0;
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 100 && (inflight != 5'd0 || exp_q.size() != 0); n++) begin
      @(negedge clock);
      #1;
    end
    check({name, "_inflight"}, {27'd0, inflight}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_queue"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_div_dividend"}, {16'd0, div_dividend}, 32'd0);
    check({name, "_div_divisor"}, {24'd0, div_divisor}, 32'd0);
    check({name, "_rsp_valid"}, {28'd0, rsp_valid}, 32'd0);
    check({name, "_rsp_quotient"}, {16'd0, rsp_quotient}, 32'd0);
    check({name, "_rsp_remainder"}, {24'd0, rsp_remainder}, 32'd0);
    check({name, "_rsp_dbz"}, {31'd0, rsp_dbz}, 32'd0);
    check({name, "_inflight"}, {27'd0, inflight}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  logic [REQ-1:0] g_v;

  initial begin
    reset        = 1'b1;
    hold         = 1'b0;
    req_valid    = 4'b0000;
    req_dividend = '0;
    req_divisor  = '0;
    for (int i = 0; i < REQ; i++) set_op(i, 16'd0, 8'd0, 16'd0, 8'd0, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    check_zero_outputs("reset");
    req_valid = 4'b1010;
    #1;
    check("reset_grant_ptr0", {28'd0, req_ready}, 32'h2);
    req_valid = 4'b0000;
    @(negedge clock);
    reset = 1'b0;

    // Fairness: everyone requests for 8 cycles
    set_op(0, 16'd1000,  8'd10,  16'd100,  8'd0,  1'b0);
    set_op(1, 16'd12345, 8'd100, 16'd123,  8'd45, 1'b0);
    set_op(2, 16'd65535, 8'd16,  16'd4095, 8'd15, 1'b0);
    set_op(3, 16'd7,     8'd9,   16'd0,    8'd7,  1'b0);
    for (int i = 0; i < 8; i++) begin
      g_v = 4'b0001 << (i % 4);
      drive(4'b1111, 1'b0, g_v, "fair_grant");
    end
    idle();
    check("fair_inflight", {27'd0, inflight}, 32'd8);
    wait_drain("fair_drain");

    // Single op 100/7
    set_op(0, 16'd100, 8'd7, 16'd14, 8'd2, 1'b0);
    drive(4'b0001, 1'b0, 4'b0001, "single_grant");
    idle();
    check("single_inflight", {27'd0, inflight}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd1);
    check("single_div_dividend", {16'd0, div_dividend}, 32'd100);
    check("single_div_divisor", {24'd0, div_divisor}, 32'd7);
    wait_drain("single_drain");

    // Divide by zero, then a normal op; hold follows while both are in flight
    set_op(2, 16'd500, 8'd0, 16'hFFFF, 8'd0, 1'b1);
    drive(4'b0100, 1'b0, 4'b0100, "dbz_grant");
    set_op(0, 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
    drive(4'b0001, 1'b0, 4'b0001, "dbz_follow_grant");
    set_op(1, 16'd300, 8'd3, 16'd100, 8'd0, 1'b0);
    set_op(3, 16'd255, 8'd2, 16'd127, 8'd1, 1'b0);
    for (int i = 0; i < 22; i++) drive(4'b1010, 1'b1, 4'b0000, "hold_ready");
    check("hold_inflight", {27'd0, inflight}, 32'd0);
    check("hold_queue", exp_q.size(), 32'd0);
    drive(4'b1010, 1'b0, 4'b0010, "hold_release_grant");
    drive(4'b1000, 1'b0, 4'b1000, "hold_second_grant");
    idle();
    wait_drain("hold_drain");

    // Reset with five ops in flight
    set_op(0, 16'd1000,  8'd10,  16'd100,  8'd0,  1'b0);
    set_op(1, 16'd12345, 8'd100, 16'd123,  8'd45, 1'b0);
    set_op(2, 16'd65535, 8'd16,  16'd4095, 8'd15, 1'b0);
    set_op(3, 16'd7,     8'd9,   16'd0,    8'd7,  1'b0);
    for (int i = 0; i < 5; i++) begin
      g_v = 4'b0001 << (i % 4);
      drive(4'b1111, 1'b0, g_v, "midflight_grant");
    end
    idle();
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_zero_outputs("async_reset");
    @(negedge clock);
    reset = 1'b0;
    set_op(2, 16'd40000, 8'd200, 16'd200, 8'd0, 1'b0);
    drive(4'b0100, 1'b0, 4'b0100, "post_reset_grant");
    idle();
    wait_drain("post_reset_drain");
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
